// File: rtl/serial_adder_controller.sv
// serial_adder_controller
//   Bit-serial adder/subtractor. One full_adder cell is reused across all
//   WIDTH bit positions, LSB first, one bit per clock. A start/busy/done
//   handshake sequences each operation. Sum, carry-out and signed overflow
//   are registered and change only on the completion edge or on reset.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   request, accepted when busy=0 (IDLE or FINISH)
//   operand_a  in   [WIDTH] augend / minuend, captured on accept
//   operand_b  in   [WIDTH] addend / subtrahend, captured on accept
//   carry_in   in   initial carry for addition, ignored when subtracting
//   subtract   in   0: a+b+carry_in, 1: a-b (a + ~b + 1)
//   busy       out  high while bits are being processed
//   done       out  one-cycle pulse, results valid from this cycle on
//   sum        out  [WIDTH] registered result
//   carry_out  out  carry out of the MSB (1 = no borrow when subtracting)
//   overflow   out  signed overflow (carry into MSB ^ carry out of MSB)

// Single-bit full adder cell shared by the sequencer.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start, outputs hold the last result
// RUN    | one operand bit per clock through the shared full adder
// FINISH | one-cycle done pulse; start here is accepted with no gap
module serial_adder_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             carry_in,
  input  logic             subtract,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PEN  = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             msb_cin_q;
  logic             sub_q;
  logic             load;
  logic             last_bit;
  logic             fa_b;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_next;
  logic             sum_sh_unused;

  // Subtraction feeds ~b; the +1 comes from presetting the carry on accept.
  assign fa_b = b_sh[0] ^ sub_q;

  full_adder u_fa (
    .a         (a_sh[0]),
    .b         (fa_b),
    .carry_in  (carry_q),
    .sum       (fa_sum),
    .carry_out (fa_cout)
  );

  assign last_bit = (cnt_q == CNT_LAST);
  assign sum_next = {fa_sum, sum_sh[WIDTH-1:1]};
  // The oldest bit falls off the shift register on every RUN edge.
  assign sum_sh_unused = sum_sh[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE, FINISH: begin
        done = (state_q == FINISH);
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_d = FINISH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      msb_cin_q <= 1'b0;
      sub_q     <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (load) begin
      a_sh    <= operand_a;
      b_sh    <= operand_b;
      carry_q <= subtract | carry_in;
      cnt_q   <= '0;
      sub_q   <= subtract;
    end else if (state_q == RUN) begin
      sum_sh  <= sum_next;
      a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
      carry_q <= fa_cout;
      cnt_q   <= cnt_q + CW'(1);
      // Carry into the MSB is the carry out of bit WIDTH-2.
      if (cnt_q == CNT_PEN) begin
        msb_cin_q <= fa_cout;
      end
      if (last_bit) begin
        sum       <= sum_next;
        carry_out <= fa_cout;
        overflow  <= msb_cin_q ^ fa_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_controller.sv
module tb_serial_adder_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, co8, ov8;
  logic [7:0] sum8;

  // 4-bit instance for the exhaustive sweep
  logic       start4 = 1'b0, cin4 = 1'b0, sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, co4, ov4;
  logic [3:0] sum4;

  serial_adder_controller #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .operand_a(a8), .operand_b(b8), .carry_in(cin8), .subtract(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8), .overflow(ov8)
  );

  serial_adder_controller #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .operand_a(a4), .operand_b(b4), .carry_in(cin4), .subtract(sub4),
    .busy(busy4), .done(done4), .sum(sum4), .carry_out(co4), .overflow(ov4)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] s;
    bit          co;
    bit          ov;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];

  // Reference: plain modular and signed integer arithmetic.
  function automatic exp_t model(input int w, input logic [31:0] a,
                                 input logic [31:0] b, input bit cin, input bit sub);
    exp_t   e;
    longint m, ua, ub, r, sa, sb, sr, ci;
    m  = longint'(1) << w;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    ci = cin ? 1 : 0;
    r  = sub ? (ua + (m - ub)) : (ua + ub + ci);
    e.co = (r >= m);
    e.s  = 32'(r % m);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    sr = sub ? (sa - sb) : (sa + sb + ci);
    e.ov = (sr < -(m / 2)) || (sr >= m / 2);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  // Monitors: pop on done, also confirm results never change without done.
  logic [9:0] prev8 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      check("busy_and_done8", {31'b0, busy8 & done8}, 32'd0);
      if (done8) begin
        if (q8.size() == 0) begin
          check("unexpected_done8", 32'd1, 32'd0);
        end else begin
          e = q8.pop_front();
          check("sum8", {24'b0, sum8}, e.s);
          check("carry_out8", {31'b0, co8}, {31'b0, e.co});
          check("overflow8", {31'b0, ov8}, {31'b0, e.ov});
        end
      end else begin
        check("hold8", {22'b0, sum8, co8, ov8}, {22'b0, prev8});
      end
    end
    prev8 = {sum8, co8, ov8};
  end

  logic [5:0] prev4 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done4) begin
        if (q4.size() == 0) begin
          check("unexpected_done4", 32'd1, 32'd0);
        end else begin
          e = q4.pop_front();
          check("sum4", {28'b0, sum4}, e.s);
          check("carry_out4", {31'b0, co4}, {31'b0, e.co});
          check("overflow4", {31'b0, ov4}, {31'b0, e.ov});
        end
      end else if ({sum4, co4, ov4} != prev4) begin
        check("hold4", {26'b0, sum4, co4, ov4}, {26'b0, prev4});
      end
    end
    prev4 = {sum4, co4, ov4};
  end

  // Issue one op on the 8-bit DUT and wait for done. poke>=0 pulses start
  // with junk operands at that RUN cycle (must be ignored).
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit cin,
                      input bit sub, input int poke);
    int cyc, busy_n;
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
    q8.push_back(model(8, {24'b0, a}, {24'b0, b}, cin, sub));
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
    cyc = 0; busy_n = 0;
    while (!done8 && cyc < 30) begin
      if (busy8) busy_n++;
      if (cyc == poke) begin
        start8 = 1'b1;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start8 = 1'b0;
    if (!done8) begin
      check("done8_timeout", 32'd0, 32'd1);
    end else begin
      check("latency8", cyc, 32'd8);
      check("busy_cycles8", busy_n, 32'd8);
    end
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input bit cin, input bit sub);
    int cyc;
    a4 = a; b4 = b; cin4 = cin; sub4 = sub; start4 = 1'b1;
    q4.push_back(model(4, {28'b0, a}, {28'b0, b}, cin, sub));
    @(posedge clk); #1;
    start4 = 1'b0;
    cyc = 0;
    while (!done4 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done4) check("done4_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    time t1, t2;
    int  seen;

    #12;
    check("rst_busy8", {31'b0, busy8}, 32'd0);
    check("rst_done8", {31'b0, done8}, 32'd0);
    check("rst_sum8", {24'b0, sum8}, 32'd0);
    check("rst_co8", {31'b0, co8}, 32'd0);
    check("rst_ov8", {31'b0, ov8}, 32'd0);
    check("rst_sum4", {28'b0, sum4}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    run8(8'h3C, 8'h5A, 1'b0, 1'b0, -1);
    run8(8'hFF, 8'h01, 1'b0, 1'b0, -1);
    run8(8'h00, 8'h00, 1'b1, 1'b0, -1);
    run8(8'h05, 8'h07, 1'b0, 1'b1, -1);
    run8(8'h05, 8'h07, 1'b1, 1'b1, -1);

    // Start pulsed mid-run is ignored
    run8(8'h21, 8'h43, 1'b0, 1'b0, 3);
    @(posedge clk); #1;

    // Back-to-back: done pulses 9 cycles apart
    run8(8'hA5, 8'h5A, 1'b1, 1'b0, -1);
    t1 = $time;
    run8(8'h80, 8'h01, 1'b0, 1'b1, -1);
    t2 = $time;
    check("b2b_spacing", 32'((t2 - t1) / 10), 32'd9);

    // Abort mid-run: accepted during FINISH of the 0x7F result, no push
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy8}, 32'd0);
    check("abort_done", {31'b0, done8}, 32'd0);
    check("abort_sum", {24'b0, sum8}, 32'd0);
    check("abort_co", {31'b0, co8}, 32'd0);
    check("abort_ov", {31'b0, ov8}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) seen++;
    end
    check("idle_after_abort", seen, 32'd0);
    run8(8'h12, 8'h34, 1'b0, 1'b0, -1);

    // Randomized
    for (int i = 0; i < 40; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
           ((i % 5) == 0) ? int'($urandom_range(0, 6)) : -1);
    end

    // Exhaustive 4-bit sweep
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 2; c++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++)
            run4(4'(a), 4'(b), c[0], s[0]);

    repeat (4) @(posedge clk);
    #1;
    check("q8_drained", q8.size(), 32'd0);
    check("q4_drained", q4.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_controller.md
# serial_adder_controller

Bit-serial adder sequencer that time-multiplexes a single 1-bit `full_adder` cell across the WIDTH bit positions of two operands. A START/BUSY/DONE handshake drives it, and it returns a registered WIDTH-bit sum, carry-out and signed-overflow flag. It sits between a requesting controller and one shared `full_adder` instance, which it owns and feeds one bit per clock, LSB first. It trades latency for area against a WIDTH-bit ripple adder.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.
- `CLK`  input  1: rising-edge clock for all state.
- `RST_N`  input  1: asynchronous, active-low reset. Clears all state and outputs immediately, regardless of CLK.
- `START`  input  1: request; sampled on a rising edge only when BUSY=0.
- `OPERAND_A`  input  WIDTH: augend/minuend; captured on the accepting edge.
- `OPERAND_B`  input  WIDTH: addend/subtrahend; captured on the accepting edge.
- `CARRY_IN`  input  1: initial carry for addition; captured on the accepting edge; ignored when SUBTRACT=1.
- `SUBTRACT`  input  1: captured on the accepting edge. 0 computes A+B+CARRY_IN; 1 computes A+~B+1 (two's-complement A−B).
- `BUSY`  output  1: high while bits are being processed (RUN state).
- `DONE`  output  1: one-cycle pulse; results valid from this cycle onward.
- `SUM`  output  WIDTH: registered result; holds until the next completion.
- `CARRY_OUT`  output  1: carry out of bit WIDTH−1.
- `OVERFLOW`  output  1: signed overflow, equal to carry into MSB XOR carry out of MSB.

## Operation
- Internal state: FSM {IDLE, RUN, FINISH}; A/B shift registers (WIDTH); sum shift register (WIDTH); carry flip-flop; bit counter of ceil(log2(WIDTH))+1 bits; MSB carry-in capture flip-flop.
- One `full_adder` instance is driven with A = A_shift[0], B = B_shift[0] (inverted when the latched SUBTRACT=1), and CARRY_IN = the carry flip-flop.
- IDLE or FINISH with START=1 on an edge (accept):
  - Load A_shift and B_shift from the operand inputs.
  - Load the carry flip-flop with SUBTRACT ? 1 : CARRY_IN.
  - Clear the counter, latch SUBTRACT, go to RUN.
- IDLE or FINISH with START=0: go to (or stay in) IDLE.
- RUN, on each edge:
  - Shift the adder SUM bit into the MSB of the sum shift register (right shift).
  - Right-shift A_shift and B_shift.
  - Load the carry flip-flop with the adder's CARRY_OUT.
  - Increment the counter.
  - On the edge that processes bit WIDTH−2, also capture the adder's CARRY_OUT as the MSB carry-in.
- RUN, on the edge processing bit WIDTH−1 (counter = WIDTH−1):
  - Load SUM from the completed shift value.
  - Load CARRY_OUT from the adder's CARRY_OUT.
  - Load OVERFLOW from the MSB carry-in XOR the adder's CARRY_OUT.
  - Go to FINISH.
- FINISH lasts one cycle with DONE=1, then returns to IDLE unless START is accepted.
- START while BUSY=1 is ignored. The operation in flight is unaffected and no request is queued.
- SUM, CARRY_OUT and OVERFLOW change only on the completion edge or on reset. They never show partial results.
- Arithmetic is modulo 2^WIDTH. CARRY_OUT is the unsigned carry; for subtraction, CARRY_OUT=1 means no borrow.

## Timing
- Reset values: state IDLE, BUSY=0, DONE=0, SUM=0, CARRY_OUT=0, OVERFLOW=0, and all internal registers 0.
- Accept on edge E0. BUSY=1 from E0 through edge E_WIDTH, i.e. for exactly WIDTH cycles.
- DONE=1 in the cycle between edges E_WIDTH and E_WIDTH+1. Results are valid from E_WIDTH.
- Latency from the accepting edge to DONE rising is WIDTH cycles. Throughput is one operation per WIDTH+1 cycles.
- Back-to-back: START=1 during the FINISH cycle is accepted on edge E_WIDTH+1.
  - BUSY rises again with no IDLE gap.
  - DONE still pulses for that FINISH cycle.
  - SUM holds the previous result until the new completion.
- DONE and BUSY are never high in the same cycle.
- Reset mid-operation: RST_N low in any state forces the reset values asynchronously.
  - The aborted operation never produces DONE.
  - After RST_N rises, the block waits in IDLE for a fresh START.
- Operand inputs may change freely after the accepting edge.

## Test plan
- WIDTH=8, add 8'h3C+8'h5A, CARRY_IN=0 → BUSY high 8 cycles, DONE on cycle 8 after accept, SUM=8'h96, CARRY_OUT=0, OVERFLOW=1.
- Add 8'hFF+8'h01, CARRY_IN=0 → SUM=8'h00, CARRY_OUT=1, OVERFLOW=0. Add 8'h00+8'h00, CARRY_IN=1 → SUM=8'h01, CARRY_OUT=0.
- SUBTRACT=1, 8'h05−8'h07, CARRY_IN=0 (ignored) → SUM=8'hFE, CARRY_OUT=0, OVERFLOW=0. 8'h80−8'h01 → SUM=8'h7F, CARRY_OUT=1, OVERFLOW=1.
- Pulse START with different operands at RUN cycle 3 → ignored; the original result is produced. START held during FINISH → second operation accepted with no gap; DONE pulses twice, 9 cycles apart.
- Assert RST_N=0 mid-cycle at RUN cycle 4 → BUSY, SUM, CARRY_OUT and OVERFLOW all go to 0 immediately, with no DONE. After release, 8'h12+8'h34 → 8'h46.
- Exhaustive WIDTH=4 sweep of all A, B, CARRY_IN and SUBTRACT combinations, compared against a behavioural A+B+cin / A−B model for SUM, CARRY_OUT and OVERFLOW.
